// File: rtl/mt9v032_lvds_word_decoder.sv
// MT9V032-style serial LVDS word decoder: finds 12-bit word alignment on a
// one-bit-per-clock stream, decodes embedded sync codes into a pixel stream.
module mt9v032_lvds_word_decoder #(
  parameter int LOCK_WORDS = 8,
  parameter int ERR_LIMIT  = 4,
  parameter int COUNT_W    = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lvds_bit,
  output logic [9:0]         pix_data,
  output logic               pix_valid,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic               frame_active,
  output logic               locked,
  output logic               sync_err,
  output logic [15:0]        frame_err_cnt,
  output logic [COUNT_W-1:0] line_count,
  output logic [COUNT_W-1:0] line_length
);

  localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
  localparam int ERRC_W = $clog2(ERR_LIMIT + 1);

  localparam logic [9:0] CODE_SYNC  = 10'd1023;
  localparam logic [9:0] CODE_ZERO  = 10'd0;
  localparam logic [9:0] CODE_LS    = 10'd1;
  localparam logic [9:0] CODE_LE    = 10'd2;
  localparam logic [9:0] CODE_FE    = 10'd3;
  localparam logic [9:0] CODE_BLANK = 10'd4;

  typedef enum logic [1:0] {AL_HUNT, AL_VERIFY, AL_LOCKED} align_state_e;
  typedef enum logic [2:0] {SY_IDLE, SY_S1, SY_S2, SY_FRAME, SY_LINE} sync_state_e;

  // Serial window and framing test
  logic [11:0] r_sr;
  logic        w_framed;
  logic [9:0]  w_word;
  logic        w_phase_end;

  assign w_framed = r_sr[0] & ~r_sr[11];
  assign w_word   = r_sr[10:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else begin
      // NOTE: non-blocking so every reader sees the pre-edge window this clock.
      r_sr <= {lvds_bit, r_sr[11:1]};
    end
  end

  // Align FSM
  align_state_e      r_align_state;
  logic [3:0]        r_phase;
  logic [GOOD_W-1:0] r_good;
  logic [ERRC_W-1:0] r_errs;
  logic [9:0]        r_word;
  logic              r_word_vld;
  logic              r_drop;
  logic              r_locked;
  logic [15:0]       r_frame_err_cnt;

  assign w_phase_end = (r_phase == 4'd11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_align_state   <= AL_HUNT;
      r_phase         <= '0;
      r_good          <= '0;
      r_errs          <= '0;
      r_word          <= '0;
      r_word_vld      <= 1'b0;
      r_drop          <= 1'b0;
      r_locked        <= 1'b0;
      r_frame_err_cnt <= '0;
    end else begin
      r_word_vld <= 1'b0;
      r_drop     <= 1'b0;
      case (r_align_state)
        AL_HUNT: begin
          if (w_framed) begin
            r_phase       <= '0;
            r_good        <= GOOD_W'(1);
            r_align_state <= AL_VERIFY;
          end
        end
        AL_VERIFY: begin
          r_phase <= w_phase_end ? 4'd0 : r_phase + 4'd1;
          if (w_phase_end) begin
            if (w_framed) begin
              r_good <= r_good + GOOD_W'(1);
              if (r_good == GOOD_W'(LOCK_WORDS - 1)) begin
                r_align_state <= AL_LOCKED;
                r_locked      <= 1'b1;
                r_errs        <= '0;
              end
            end else begin
              r_align_state <= AL_HUNT;
            end
          end
        end
        AL_LOCKED: begin
          r_phase <= w_phase_end ? 4'd0 : r_phase + 4'd1;
          if (w_phase_end) begin
            r_word <= w_word;
            if (w_framed) begin
              r_errs     <= '0;
              r_word_vld <= 1'b1;
            end else begin
              if (r_frame_err_cnt != 16'hFFFF) r_frame_err_cnt <= r_frame_err_cnt + 16'd1;
              if (r_errs == ERRC_W'(ERR_LIMIT - 1)) begin
                // Lock lost: the sync FSM is told via r_drop instead of a word
                r_align_state <= AL_HUNT;
                r_locked      <= 1'b0;
                r_drop        <= 1'b1;
                r_errs        <= '0;
              end else begin
                r_errs     <= r_errs + ERRC_W'(1);
                r_word_vld <= 1'b1;
              end
            end
          end
        end
        default: r_align_state <= AL_HUNT;
      endcase
    end
  end

  // Sync FSM and one-deep pixel holder
  sync_state_e        r_sync_state;
  logic [9:0]         r_hold;
  logic               r_hold_vld;
  logic               r_sof_pend;
  logic [COUNT_W-1:0] r_pix_cnt;
  logic [COUNT_W-1:0] r_line_cnt;
  logic [9:0]         r_pix_data;
  logic               r_pix_valid;
  logic               r_pix_sof;
  logic               r_pix_eol;
  logic               r_frame_active;
  logic               r_sync_err;
  logic [COUNT_W-1:0] r_line_count;
  logic [COUNT_W-1:0] r_line_length;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_state   <= SY_IDLE;
      r_hold         <= '0;
      r_hold_vld     <= 1'b0;
      r_sof_pend     <= 1'b0;
      r_pix_cnt      <= '0;
      r_line_cnt     <= '0;
      r_pix_data     <= '0;
      r_pix_valid    <= 1'b0;
      r_pix_sof      <= 1'b0;
      r_pix_eol      <= 1'b0;
      r_frame_active <= 1'b0;
      r_sync_err     <= 1'b0;
      r_line_count   <= '0;
      r_line_length  <= '0;
    end else begin
      r_pix_valid <= 1'b0;
      r_pix_sof   <= 1'b0;
      r_pix_eol   <= 1'b0;
      r_sync_err  <= 1'b0;
      if (r_drop) begin
        r_sync_state   <= SY_IDLE;
        r_hold_vld     <= 1'b0;
        r_frame_active <= 1'b0;
        r_sync_err     <= 1'b1;
      end else if (r_word_vld) begin
        case (r_sync_state)
          SY_IDLE: if (r_word == CODE_SYNC) r_sync_state <= SY_S1;
          SY_S1: begin
            if (r_word == CODE_ZERO)      r_sync_state <= SY_S2;
            else if (r_word != CODE_SYNC) r_sync_state <= SY_IDLE;
          end
          SY_S2: begin
            if (r_word == CODE_SYNC) begin
              r_sync_state   <= SY_FRAME;
              r_frame_active <= 1'b1;
              r_sof_pend     <= 1'b1;
              r_line_cnt     <= '0;
            end else begin
              r_sync_state <= SY_IDLE;
            end
          end
          SY_FRAME: begin
            if (r_word == CODE_LS) begin
              r_sync_state <= SY_LINE;
              r_pix_cnt    <= '0;
            end else if (r_word != CODE_BLANK) begin
              r_sync_state   <= SY_IDLE;
              r_frame_active <= 1'b0;
              r_sync_err     <= 1'b1;
            end
          end
          SY_LINE: begin
            if (r_word == CODE_LE || r_word == CODE_FE) begin
              if (r_hold_vld) begin
                r_pix_valid   <= 1'b1;
                r_pix_data    <= r_hold;
                r_pix_sof     <= r_sof_pend;
                r_pix_eol     <= 1'b1;
                r_sof_pend    <= 1'b0;
                r_line_length <= r_pix_cnt;
              end
              r_hold_vld <= 1'b0;
              if (r_word == CODE_LE) begin
                r_sync_state <= SY_FRAME;
                if (r_hold_vld) r_line_cnt <= r_line_cnt + COUNT_W'(1);
              end else begin
                r_sync_state   <= SY_IDLE;
                r_frame_active <= 1'b0;
                r_line_count   <= r_line_cnt + COUNT_W'(r_hold_vld);
                r_line_cnt     <= '0;
              end
            end else if (r_word == CODE_ZERO || r_word == CODE_LS) begin
              r_sync_state   <= SY_IDLE;
              r_hold_vld     <= 1'b0;
              r_frame_active <= 1'b0;
              r_sync_err     <= 1'b1;
            end else begin
              if (r_hold_vld) begin
                r_pix_valid <= 1'b1;
                r_pix_data  <= r_hold;
                r_pix_sof   <= r_sof_pend;
                r_sof_pend  <= 1'b0;
              end
              r_hold     <= r_word;
              r_hold_vld <= 1'b1;
              r_pix_cnt  <= r_pix_cnt + COUNT_W'(1);
            end
          end
          default: r_sync_state <= SY_IDLE;
        endcase
      end
    end
  end

  assign pix_data      = r_pix_data;
  assign pix_valid     = r_pix_valid;
  assign pix_sof       = r_pix_sof;
  assign pix_eol       = r_pix_eol;
  assign frame_active  = r_frame_active;
  assign locked        = r_locked;
  assign sync_err      = r_sync_err;
  assign frame_err_cnt = r_frame_err_cnt;
  assign line_count    = r_line_count;
  assign line_length   = r_line_length;

endmodule
